wave_osc: RTL and testbench
===========================

WAVE_OSC -- requirements
Module: wave_osc

Interface
REQ-001 SHALL have parameter WIDTH, default 24, output sample width in bits.
REQ-002 SHALL have parameter PERIOD_W, default 16, width of the period count.
REQ-003 SHALL have parameter DEF_PERIOD, default 5000, active period after reset.
REQ-004 SHALL have parameter DEF_STEP, default 70, active step after reset.
REQ-005 SHALL have port CLOCK_50  input  1  the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  high = oscillator runs; low = state frozen.
REQ-008 SHALL have port tick  input  1  sample-rate strobe; phase advances only on cycles with enable=1 and tick=1.
REQ-009 SHALL have port mode  input  2  00 saw, 01 square, 10 triangle, 11 mute.
REQ-010 SHALL have port period  input  PERIOD_W  requested period in ticks.
REQ-011 SHALL have port step  input  WIDTH  requested amplitude increment per tick.
REQ-012 SHALL have port load  input  1  one-cycle strobe capturing mode/period/step into shadow registers.
REQ-013 SHALL have port out  output  WIDTH  registered sample.
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse marking the period boundary.
REQ-015 SHALL have port pending  output  1  high while a loaded configuration awaits activation.

Function
REQ-016 SHALL hold active registers (A_mode, A_period, A_step), shadow registers, phase count cnt (PERIOD_W bits) and amplitude acc (WIDTH bits).
REQ-017 SHALL clamp an effective period P = max(A_period, 2); period values 0 and 1 both behave as 2.
REQ-018 On load=1: shadow <= inputs, pending <= 1; a second load before activation overwrites the shadow.
REQ-019 Advance cycle (enable=1, tick=1), cnt = P-1: cnt <= 0, acc <= 0, wrap <= 1 next cycle, and pending shadow copied to active (pending <= 0).
REQ-020 Advance cycle, cnt < P-1: cnt <= cnt+1; wrap <= 0.
REQ-021 Saw: acc <= min(acc + A_step, 2^WIDTH-1) (saturating, no wrap-around).
REQ-022 Triangle: if cnt < P>>1 then acc <= saturating acc + A_step, else acc <= (acc >= A_step) ? acc - A_step : 0.
REQ-023 Square: out <= all-ones when the new cnt >= P>>1, else 0.
REQ-024 Mute: out <= 0; cnt, acc and wrap continue exactly as saw.
REQ-025 Saw/triangle: out <= new acc value; out thus lags the advancing tick by exactly one clock.
REQ-026 Non-advance cycle with enable=1: cnt, acc, out held; wrap <= 0.
REQ-027 enable=0: cnt, acc, out held; wrap <= 0; pending shadow copied to active on that cycle (no boundary wait).
REQ-028 load and activation in the same cycle: the newly presented inputs become active and pending <= 0.
REQ-029 Activation SHALL NOT reset cnt/acc except at the boundary already defined in REQ-019.
REQ-030 A_period smaller than current cnt+1 after activation via REQ-027: next advance treats cnt >= P-1 as boundary (wrap per REQ-019).

Reset
REQ-031 reset=0 at a clock edge: out <= 0, wrap <= 0, pending <= 0, cnt <= 0, acc <= 0, A_mode <= 00, A_period <= DEF_PERIOD, A_step <= DEF_STEP, shadow <= same defaults.
REQ-032 reset SHALL take priority over load, enable and tick, including mid-period and mid-pending; a pending configuration is discarded.

Verification
REQ-033 Reset, enable=1, tick=1 constant, defaults: out = 70, 140, ... reaching 349930 at cnt=4999, then out=0 and wrap high one cycle; period repeats every 5000 clocks.
REQ-034 WIDTH=8, step=100, period=8, saw: out = 100, 200, 255, 255, ..., 0 at boundary (saturation verified).
REQ-035 Triangle, period=8, step=10, tick every 4th clock: out 10,20,30,40,30,20,10,0 changing only one clock after each tick.
REQ-036 Square, period=6: out = 0,0,all-ones,all-ones,all-ones,0 per tick (new cnt 1..5 then 0).
REQ-037 load period=4 mid-period with enable=1: pending=1 until the old period's boundary, then 4-tick periods; load with enable=0: active next cycle, pending low.
REQ-038 reset asserted mid-period with pending=1: next cycle out=0, wrap=0, pending=0, defaults active.

Source files
------------

// File: rtl/wave_osc.sv
// Waveform oscillator: saw / square / triangle / mute, phase advanced on sample ticks.
// Latency: out and wrap are registered, one clock after the advancing tick edge.
// Backpressure: none; enable=0 freezes the phase state, tick gates each advance.
//
// Ports:
//   CLOCK_50          system clock, all logic on its rising edge
//   reset             synchronous active-low reset
//   enable            run (1) / freeze (0) the oscillator
//   tick              sample-rate strobe, advances phase when enable=1
//   mode              00 saw, 01 square, 10 triangle, 11 mute
//   period            requested period in ticks (0 and 1 behave as 2)
//   step              requested amplitude increment per tick
//   load              one-cycle strobe capturing mode/period/step into the shadow set
//   out               registered sample
//   wrap              one-cycle pulse marking the period boundary
//   pending           a loaded configuration is waiting to become active
module wave_osc #(
   parameter int WIDTH      = 24,
   parameter int PERIOD_W   = 16,
   parameter int DEF_PERIOD = 5000,
   parameter int DEF_STEP   = 70
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                enable,
   input  logic                tick,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] period,
   input  logic [WIDTH-1:0]    step,
   input  logic                load,
   output logic [WIDTH-1:0]    out,
   output logic                wrap,
   output logic                pending
);

   typedef enum logic [1:0] {
      MODE_SAW    = 2'b00,
      MODE_SQUARE = 2'b01,
      MODE_TRI    = 2'b10,
      MODE_MUTE   = 2'b11
   } mode_t;

   // Active configuration (drives the waveform) and shadow configuration
   // (captured by load, promoted at the next activation point).
   mode_t               a_mode;
   logic [PERIOD_W-1:0] a_period;
   logic [WIDTH-1:0]    a_step;
   mode_t               s_mode;
   logic [PERIOD_W-1:0] s_period;
   logic [WIDTH-1:0]    s_step;

   logic [PERIOD_W-1:0] cnt;
   logic [WIDTH-1:0]    acc;

   // Combinational next-state terms
   logic [PERIOD_W-1:0] p_eff;
   logic [PERIOD_W-1:0] p_last;
   logic [PERIOD_W-1:0] p_half;
   logic                adv;
   logic                is_bnd;
   logic                act;
   logic [PERIOD_W-1:0] cnt_nxt;
   logic [WIDTH:0]      sum_ext;
   logic [WIDTH-1:0]    acc_add;
   logic [WIDTH-1:0]    acc_sub;
   logic [WIDTH-1:0]    acc_nxt;
   logic [WIDTH-1:0]    out_nxt;

   always_comb begin
      p_eff   = (a_period < PERIOD_W'(2)) ? PERIOD_W'(2) : a_period;
      p_last  = p_eff - PERIOD_W'(1);
      p_half  = p_eff >> 1;
      adv     = enable & tick;
      // ">=" rather than "==" so a period shrunk below the current phase
      // by a frozen-state activation still ends at the next advance.
      is_bnd  = (cnt >= p_last);
      // A configuration becomes active immediately while frozen, or at the
      // boundary advance. A load presented on that same cycle wins.
      act     = (pending | load) & (~enable | (adv & is_bnd));

      sum_ext = {1'b0, acc} + {1'b0, a_step};
      acc_add = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
      acc_sub = (acc >= a_step) ? (acc - a_step) : '0;

      cnt_nxt = '0;
      acc_nxt = '0;
      out_nxt = '0;
      if (!is_bnd) begin
         cnt_nxt = cnt + PERIOD_W'(1);
         // Square and mute keep the accumulator moving like saw so that a
         // later mode change picks up a consistent phase/amplitude pair.
         if (a_mode == MODE_TRI)
            acc_nxt = (cnt < p_half) ? acc_add : acc_sub;
         else
            acc_nxt = acc_add;
         case (a_mode)
            MODE_SAW:    out_nxt = acc_nxt;
            MODE_TRI:    out_nxt = acc_nxt;
            MODE_SQUARE: out_nxt = (cnt_nxt >= p_half) ? {WIDTH{1'b1}} : '0;
            default:     out_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         out      <= '0;
         wrap     <= 1'b0;
         pending  <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         a_mode   <= MODE_SAW;
         a_period <= PERIOD_W'(DEF_PERIOD);
         a_step   <= WIDTH'(DEF_STEP);
         s_mode   <= MODE_SAW;
         s_period <= PERIOD_W'(DEF_PERIOD);
         s_step   <= WIDTH'(DEF_STEP);
      end else begin
         wrap <= 1'b0;

         if (load) begin
            s_mode   <= mode_t'(mode);
            s_period <= period;
            s_step   <= step;
            pending  <= 1'b1;
         end

         if (act) begin
            a_mode   <= load ? mode_t'(mode) : s_mode;
            a_period <= load ? period : s_period;
            a_step   <= load ? step : s_step;
            pending  <= 1'b0;
         end

         if (adv) begin
            cnt  <= cnt_nxt;
            acc  <= acc_nxt;
            out  <= out_nxt;
            wrap <= is_bnd;
         end
      end
   end

endmodule

// File: tb/tb_wave_osc.sv
// Directed bench for wave_osc: default saw, saturation (8-bit instance),
// triangle with sparse ticks, square, mute, period clamp, reload and reset.
module tb_wave_osc;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b0;
   logic        enable   = 1'b0;
   logic        tick     = 1'b0;
   logic [1:0]  mode     = 2'b00;
   logic [15:0] period   = 16'd0;
   logic [23:0] step     = 24'd0;
   logic [7:0]  step8    = 8'd0;
   logic        load     = 1'b0;
   logic [23:0] out;
   logic        wrap;
   logic        pending;
   logic [7:0]  out8;
   logic        wrap8;
   logic        pending8;

   int checks = 0;
   int errors = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   wave_osc dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .tick(tick),
      .mode(mode), .period(period), .step(step), .load(load),
      .out(out), .wrap(wrap), .pending(pending)
   );

   wave_osc #(.WIDTH(8)) dut8 (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .tick(tick),
      .mode(mode), .period(period), .step(step8), .load(load),
      .out(out8), .wrap(wrap8), .pending(pending8)
   );

   // Advance one clock and settle just after the edge.
   task automatic step_clk();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Reset both instances, then load a configuration while frozen so it is
   // active on the following cycle with phase at zero.
   task automatic reset_and_load(input logic [1:0] m, input logic [15:0] p,
                                 input logic [23:0] s, input logic [7:0] s8);
      reset = 1'b0; enable = 1'b0; tick = 1'b0; load = 1'b0;
      step_clk();
      reset = 1'b1;
      mode = m; period = p; step = s; step8 = s8; load = 1'b1;
      step_clk();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; tick = 1'b1; load = 1'b1;
      mode = 2'b01; period = 16'd3; step = 24'd9;
      step_clk();
      checks++;
      if (out !== 24'd0 || wrap !== 1'b0 || pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out=%0d wrap=%b pending=%b, want 0 0 0", out, wrap, pending);
      end
      load = 1'b0; enable = 1'b0; tick = 1'b0;
   endtask

   task automatic test_default_saw();
      logic [23:0] exp_out;
      reset = 1'b0; enable = 1'b0; tick = 1'b0; load = 1'b0;
      step_clk();
      reset = 1'b1; enable = 1'b1; tick = 1'b1;
      for (int k = 1; k <= 5001; k++) begin
         step_clk();
         exp_out = (k == 5000) ? 24'd0 : (k == 5001) ? 24'd70 : 24'(70 * k);
         checks++;
         if (out !== exp_out || wrap !== (k == 5000)) begin
            errors++;
            $display("FAIL default_saw k=%0d: out=%0d wrap=%b, want %0d %b", k, out, wrap, exp_out, (k == 5000));
         end
      end
      checks++;
      if (dut.cnt !== 16'd1) begin
         errors++;
         $display("FAIL default_saw_phase: cnt=%0d, want 1", dut.cnt);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] exp8 [8];
      exp8 = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
      reset_and_load(2'b00, 16'd8, 24'd1, 8'd100);
      enable = 1'b1; tick = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step_clk();
         checks++;
         if (out8 !== exp8[i] || wrap8 !== (i == 7)) begin
            errors++;
            $display("FAIL saturation i=%0d: out=%0d wrap=%b, want %0d %b", i, out8, wrap8, exp8[i], (i == 7));
         end
      end
   endtask

   task automatic test_triangle();
      logic [23:0] exp_tri [8];
      logic [23:0] prev;
      exp_tri = '{24'd10, 24'd20, 24'd30, 24'd40, 24'd30, 24'd20, 24'd10, 24'd0};
      reset_and_load(2'b10, 16'd8, 24'd10, 8'd1);
      enable = 1'b1;
      prev = 24'd0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out !== prev) begin
            errors++;
            $display("FAIL triangle_pre i=%0d: out=%0d, want %0d", i, out, prev);
         end
         tick = 1'b1;
         step_clk();
         tick = 1'b0;
         checks++;
         if (out !== exp_tri[i] || wrap !== (i == 7)) begin
            errors++;
            $display("FAIL triangle i=%0d: out=%0d wrap=%b, want %0d %b", i, out, wrap, exp_tri[i], (i == 7));
         end
         for (int j = 0; j < 3; j++) begin
            step_clk();
            checks++;
            if (out !== exp_tri[i] || wrap !== 1'b0) begin
               errors++;
               $display("FAIL triangle_hold i=%0d j=%0d: out=%0d wrap=%b, want %0d 0", i, j, out, wrap, exp_tri[i]);
            end
         end
         prev = exp_tri[i];
      end
   endtask

   task automatic test_square();
      logic [23:0] ones;
      logic [23:0] exp_sq [6];
      ones = 24'hFFFFFF;
      exp_sq = '{24'd0, 24'd0, ones, ones, ones, 24'd0};
      reset_and_load(2'b01, 16'd6, 24'd5, 8'd1);
      enable = 1'b1; tick = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step_clk();
         checks++;
         if (out !== exp_sq[i % 6] || wrap !== ((i % 6) == 5)) begin
            errors++;
            $display("FAIL square i=%0d: out=%h wrap=%b, want %h %b", i, out, wrap, exp_sq[i % 6], ((i % 6) == 5));
         end
      end
   endtask

   task automatic test_mute();
      reset_and_load(2'b11, 16'd4, 24'd5, 8'd1);
      enable = 1'b1; tick = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step_clk();
         checks++;
         if (out !== 24'd0 || wrap !== ((i % 4) == 3)) begin
            errors++;
            $display("FAIL mute i=%0d: out=%0d wrap=%b, want 0 %b", i, out, wrap, ((i % 4) == 3));
         end
      end
   endtask

   task automatic test_clamp();
      logic [15:0] pv [2];
      pv = '{16'd0, 16'd1};
      for (int v = 0; v < 2; v++) begin
         reset_and_load(2'b00, pv[v], 24'd10, 8'd1);
         enable = 1'b1; tick = 1'b1;
         for (int i = 0; i < 4; i++) begin
            step_clk();
            checks++;
            if (out !== (((i % 2) == 0) ? 24'd10 : 24'd0) || wrap !== ((i % 2) == 1)) begin
               errors++;
               $display("FAIL clamp p=%0d i=%0d: out=%0d wrap=%b, want %0d %b", pv[v], i, out, wrap,
                        (((i % 2) == 0) ? 10 : 0), ((i % 2) == 1));
            end
         end
      end
   endtask

   task automatic test_reload();
      // cycle: load, out, wrap, pending expected after each edge
      logic        ld   [24];
      logic        en   [24];
      logic [15:0] lp   [24];
      logic [23:0] eo   [24];
      logic        ew   [24];
      logic        ep   [24];
      reset_and_load(2'b00, 16'd8, 24'd10, 8'd1);
      for (int c = 0; c < 24; c++) begin
         ld[c] = 1'b0; en[c] = 1'b1; lp[c] = 16'd0; ew[c] = 1'b0; ep[c] = 1'b0;
      end
      eo = '{24'd10, 24'd20, 24'd30, 24'd40, 24'd50, 24'd60, 24'd70, 24'd0,
             24'd20, 24'd40, 24'd60, 24'd0,  24'd20, 24'd20, 24'd25, 24'd30,
             24'd35, 24'd40, 24'd0,  24'd5,  24'd10, 24'd15, 24'd15, 24'd0};
      // load period 4 step 20 mid-period while running
      ld[3] = 1'b1; lp[3] = 16'd4;
      ep[3] = 1'b1; ep[4] = 1'b1; ep[5] = 1'b1; ep[6] = 1'b1;
      ew[7] = 1'b1; ew[11] = 1'b1;
      // frozen load: period 6 step 5, active immediately
      ld[13] = 1'b1; en[13] = 1'b0; lp[13] = 16'd6;
      ew[18] = 1'b1;
      // frozen load of period 2 at cnt=3: next advance is a boundary
      ld[22] = 1'b1; en[22] = 1'b0; lp[22] = 16'd2;
      ew[23] = 1'b1;
      tick = 1'b1; mode = 2'b00;
      for (int c = 0; c < 24; c++) begin
         load = ld[c]; enable = en[c];
         if (ld[c]) begin
            period = lp[c];
            step = (lp[c] == 16'd4) ? 24'd20 : 24'd5;
         end
         step_clk();
         load = 1'b0;
         checks++;
         if (out !== eo[c] || wrap !== ew[c] || pending !== ep[c]) begin
            errors++;
            $display("FAIL reload c=%0d: out=%0d wrap=%b pending=%b, want %0d %b %b",
                     c, out, wrap, pending, eo[c], ew[c], ep[c]);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset_and_load(2'b00, 16'd8, 24'd10, 8'd1);
      enable = 1'b1; tick = 1'b1;
      step_clk(); step_clk();
      mode = 2'b10; period = 16'd4; step = 24'd3; load = 1'b1;
      step_clk();
      load = 1'b0;
      checks++;
      if (pending !== 1'b1 || out !== 24'd30) begin
         errors++;
         $display("FAIL reset_mid_pre: out=%0d pending=%b, want 30 1", out, pending);
      end
      reset = 1'b0; load = 1'b1;
      step_clk();
      checks++;
      if (out !== 24'd0 || wrap !== 1'b0 || pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: out=%0d wrap=%b pending=%b, want 0 0 0", out, wrap, pending);
      end
      reset = 1'b1; load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step_clk();
         checks++;
         if (out !== 24'(70 * i) || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_defaults i=%0d: out=%0d pending=%b, want %0d 0", i, out, pending, 70 * i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_saw();
      test_saturation();
      test_triangle();
      test_square();
      test_mute();
      test_clamp();
      test_reload();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
